// File: rtl/xy_link_pkg.sv
// ---------------------------------------------------------------------------
// xy_link_pkg
// Shared types and constants for the receive end of the 3-input
// logic-encoder serial link.
//   state_t          receiver FSM states
//   FRAME_DATA_BITS  payload bits per frame (o, x, y)
//   BIT_O/BIT_X/BIT_Y  payload bit positions, in order of arrival
//   decode_c()       recovers c from the received x and o bits
// ---------------------------------------------------------------------------
package xy_link_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        DECODE
    } state_t;

    localparam int FRAME_DATA_BITS = 3;

    localparam int BIT_O = 0;
    localparam int BIT_X = 1;
    localparam int BIT_Y = 2;

    // The encoder sends x = ~c ^ o, so c = ~(x ^ o).
    function automatic logic decode_c(input logic x, input logic o);
        return ~(x ^ o);
    endfunction

endpackage

// File: rtl/xy_baud_tick.sv
// ---------------------------------------------------------------------------
// xy_baud_tick
// Free-running bit-period counter for the serial receiver.
//   clk        system clock
//   rst_n      asynchronous active-low reset
//   clear      synchronous restart: counter is 0 on the following cycle
//   half_tick  high while the counter sits at CLKS_PER_BIT/2 - 1
//   full_tick  high while the counter sits at CLKS_PER_BIT - 1 (then wraps)
// After a clear, half_tick first fires CLKS_PER_BIT/2 cycles later and
// full_tick fires every CLKS_PER_BIT cycles.
// ---------------------------------------------------------------------------
module xy_baud_tick #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    output logic half_tick,
    output logic full_tick
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL_LAST = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] cnt;

    // NOTE: sequential state uses non-blocking (<=) so every flop samples
    // the pre-edge values of its inputs, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clear || cnt == FULL_LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign half_tick = (cnt == HALF_LAST);
    assign full_tick = (cnt == FULL_LAST);

endmodule

// File: rtl/xy_serial_decoder.sv
// ---------------------------------------------------------------------------
// xy_serial_decoder
// Receives UART-style frames {start=0, o, x, y, stop=1} carrying the output of
// the 3-input logic encoder (y=a&b, x=~c^(a|b), o=a|b), recovers c, a&b and
// a|b, flags impossible codes, and packs recovered c bits MSB-first into words.
//   clk         system clock
//   rst_n       asynchronous active-low reset
//   rxd         serial line, idle high, asynchronous to clk
//   sym_valid   1-cycle pulse: good frame decoded
//   c_out       recovered c (held between pulses)
//   and_ab      recovered a&b (held between pulses)
//   or_ab       recovered a|b (held between pulses)
//   code_err    1-cycle pulse: y=1 with o=0 received
//   frame_err   1-cycle pulse: stop bit sampled low
//   word        last completed word, first-received c in the MSB
//   word_valid  1-cycle pulse, the cycle after the sym_valid that filled word
// ---------------------------------------------------------------------------
module xy_serial_decoder
    import xy_link_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16,
    parameter int WORD_W       = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rxd,
    output logic              sym_valid,
    output logic              c_out,
    output logic              and_ab,
    output logic              or_ab,
    output logic              code_err,
    output logic              frame_err,
    output logic [WORD_W-1:0] word,
    output logic              word_valid
);

    localparam logic [1:0] LAST_BIT = 2'(FRAME_DATA_BITS - 1);
    localparam int CNT_W = $clog2(WORD_W + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WORD_W - 1);

    // Input synchroniser plus one extra flop for falling-edge detection.
    // All three reset to 1 so a released reset never looks like a start edge.
    logic sync1, rxd_s, rxd_q;
    logic fall;

    state_t state, state_next;
    logic [1:0] bit_cnt;
    logic [FRAME_DATA_BITS-1:0] data;

    logic baud_clear, half_tick, full_tick;
    logic load_bit, sym_set, code_set, ferr_set;

    logic [WORD_W-1:0] shreg;
    logic [WORD_W-1:0] shifted;
    logic [CNT_W-1:0]  count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 1'b1;
            rxd_s <= 1'b1;
            rxd_q <= 1'b1;
        end else begin
            sync1 <= rxd;
            rxd_s <= sync1;
            rxd_q <= rxd_s;
        end
    end

    // Edge-triggered start: a line held low after a frame error never restarts.
    assign fall = rxd_q & ~rxd_s;

    xy_baud_tick #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (baud_clear),
        .half_tick(half_tick),
        .full_tick(full_tick)
    );

    // NOTE: every signal driven here gets a default first, so no path leaves
    // one unassigned and no latch is inferred.
    always_comb begin
        state_next = state;
        baud_clear = 1'b0;
        load_bit   = 1'b0;
        sym_set    = 1'b0;
        code_set   = 1'b0;
        ferr_set   = 1'b0;
        case (state)
            IDLE: begin
                if (fall) begin
                    state_next = START;
                    baud_clear = 1'b1;
                end
            end
            START: begin
                if (half_tick) begin
                    if (!rxd_s) begin
                        // Re-align so full ticks land at mid-bit from here on.
                        state_next = DATA;
                        baud_clear = 1'b1;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            DATA: begin
                if (full_tick) begin
                    load_bit = 1'b1;
                    if (bit_cnt == LAST_BIT) begin
                        state_next = STOP;
                    end
                end
            end
            STOP: begin
                if (full_tick) begin
                    if (rxd_s) begin
                        state_next = DECODE;
                    end else begin
                        ferr_set   = 1'b1;
                        state_next = IDLE;
                    end
                end
            end
            DECODE: begin
                state_next = IDLE;
                if (data[BIT_Y] && !data[BIT_O]) begin
                    code_set = 1'b1;
                end else begin
                    sym_set = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            bit_cnt <= '0;
            data    <= '0;
        end else begin
            state <= state_next;
            if (state == START) begin
                bit_cnt <= '0;
            end else if (load_bit) begin
                data[bit_cnt] <= rxd_s;
                bit_cnt       <= bit_cnt + 1'b1;
            end
        end
    end

    // Registered result pulses and held decoded values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sym_valid <= 1'b0;
            code_err  <= 1'b0;
            frame_err <= 1'b0;
            c_out     <= 1'b0;
            and_ab    <= 1'b0;
            or_ab     <= 1'b0;
        end else begin
            sym_valid <= sym_set;
            code_err  <= code_set;
            frame_err <= ferr_set;
            if (sym_set) begin
                c_out  <= decode_c(data[BIT_X], data[BIT_O]);
                and_ab <= data[BIT_Y];
                or_ab  <= data[BIT_O];
            end
        end
    end

    // Word packer works off the registered sym_valid/c_out, which places
    // word_valid one cycle after the sym_valid that completes the word.
    assign shifted = {shreg[WORD_W-2:0], c_out};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg      <= '0;
            count      <= '0;
            word       <= '0;
            word_valid <= 1'b0;
        end else begin
            word_valid <= 1'b0;
            if (code_set) begin
                count <= '0;
            end else if (sym_valid) begin
                shreg <= shifted;
                if (count == CNT_LAST) begin
                    word       <= shifted;
                    word_valid <= 1'b1;
                    count      <= '0;
                end else begin
                    count <= count + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_xy_serial_decoder.sv
// ---------------------------------------------------------------------------
// tb_xy_serial_decoder
// Directed stimulus drives serial frames; expected decode events and words
// are queued when a frame is issued, and a negedge monitor pops and compares
// them whenever the decoder pulses an output.
// ---------------------------------------------------------------------------
module tb_xy_serial_decoder;

    localparam int CPB = 4;
    localparam int WW  = 4;

    localparam logic [2:0] K_SYM   = 3'b100;
    localparam logic [2:0] K_CODE  = 3'b010;
    localparam logic [2:0] K_FRAME = 3'b001;

    typedef struct {
        logic [2:0] kind;
        logic       c;
        logic       a_and_b;
        logic       a_or_b;
    } ev_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          rxd = 1'b1;
    logic          sym_valid, c_out, and_ab, or_ab, code_err, frame_err, word_valid;
    logic [WW-1:0] word;

    ev_t           ev_q[$];
    logic [WW-1:0] word_q[$];
    logic [WW-1:0] m_sh = '0;
    int            m_cnt = 0;

    int n_pass = 0;
    int n_total = 0;

    xy_serial_decoder #(
        .CLKS_PER_BIT(CPB),
        .WORD_W      (WW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rxd       (rxd),
        .sym_valid (sym_valid),
        .c_out     (c_out),
        .and_ab    (and_ab),
        .or_ab     (or_ab),
        .code_err  (code_err),
        .frame_err (frame_err),
        .word      (word),
        .word_valid(word_valid)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_total++;
        if (actual === expected) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic send_bit(input logic v);
        rxd = v;
        repeat (CPB) @(posedge clk);
        #1;
    endtask

    task automatic send_raw(input logic o, input logic x, input logic y, input logic stop);
        send_bit(1'b0);
        send_bit(o);
        send_bit(x);
        send_bit(y);
        send_bit(stop);
    endtask

    // Encodes (a,b,c) as the far side does and queues the expected result.
    task automatic send_abc(input logic a, input logic b, input logic c);
        ev_t e;
        logic o, x, y;
        o = a | b;
        x = ~c ^ o;
        y = a & b;
        e.kind = K_SYM;
        e.c = c;
        e.a_and_b = y;
        e.a_or_b = o;
        ev_q.push_back(e);
        m_sh = {m_sh[WW-2:0], c};
        m_cnt++;
        if (m_cnt == WW) begin
            word_q.push_back(m_sh);
            m_cnt = 0;
        end
        send_raw(o, x, y, 1'b1);
    endtask

    task automatic send_code_err();
        ev_t e;
        e.kind = K_CODE;
        e.c = 1'b0;
        e.a_and_b = 1'b0;
        e.a_or_b = 1'b0;
        ev_q.push_back(e);
        m_cnt = 0;
        send_raw(1'b0, 1'b0, 1'b1, 1'b1);
    endtask

    task automatic send_frame_err();
        ev_t e;
        e.kind = K_FRAME;
        e.c = 1'b0;
        e.a_and_b = 1'b0;
        e.a_or_b = 1'b0;
        ev_q.push_back(e);
        send_raw(1'b1, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic idle_bits(input int n);
        for (int i = 0; i < n; i++) send_bit(1'b1);
    endtask

    task automatic check_all_zero(input string name);
        check(name, {24'd0, sym_valid, code_err, frame_err, word_valid, c_out, and_ab, or_ab, 1'b0},
              32'd0);
        check({name, "_word"}, 32'(word), 32'd0);
    endtask

    // Monitor: compare every output pulse against the head of its queue.
    always @(negedge clk) begin
        int  n;
        ev_t e;
        if (rst_n) begin
            n = int'(sym_valid) + int'(code_err) + int'(frame_err);
            if (n > 0) begin
                check("pulse_count", 32'(n), 32'd1);
                if (ev_q.size() == 0) begin
                    check("unexpected_pulse", {29'd0, sym_valid, code_err, frame_err}, 32'd0);
                end else begin
                    e = ev_q.pop_front();
                    check("pulse_kind", {29'd0, sym_valid, code_err, frame_err}, {29'd0, e.kind});
                    if (e.kind == K_SYM) begin
                        check("c_out", 32'(c_out), 32'(e.c));
                        check("and_ab", 32'(and_ab), 32'(e.a_and_b));
                        check("or_ab", 32'(or_ab), 32'(e.a_or_b));
                    end
                end
            end
            if (word_valid) begin
                if (word_q.size() == 0) begin
                    check("unexpected_word", 32'(word_valid), 32'd0);
                end else begin
                    check("word", 32'(word), 32'(word_q.pop_front()));
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        // Reset state
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset_outputs");
        rst_n = 1'b1;
        idle_bits(2);

        // 1: a=1,b=0,c=1 -> o=1,x=1,y=0
        send_abc(1'b1, 1'b0, 1'b1);
        idle_bits(2);
        check("c_out_hold", 32'(c_out), 32'd1);

        // 2: all eight combinations back-to-back
        for (int i = 0; i < 8; i++) begin
            logic [2:0] v;
            v = 3'(i);
            send_abc(v[2], v[1], v[0]);
        end
        idle_bits(2);

        // 3: impossible code, then c = 1,0,1,1 -> word 4'b1011
        send_code_err();
        send_abc(1'b0, 1'b0, 1'b1);
        send_abc(1'b0, 1'b1, 1'b0);
        send_abc(1'b1, 1'b1, 1'b1);
        send_abc(1'b0, 1'b0, 1'b1);
        idle_bits(2);

        // 4: stop bit low -> frame_err only, then a good frame
        send_frame_err();
        idle_bits(2);
        send_abc(1'b1, 1'b1, 1'b0);
        idle_bits(2);

        // 5: one-cycle glitch on the idle line, then a good frame
        rxd = 1'b0;
        @(posedge clk);
        #1;
        rxd = 1'b1;
        idle_bits(3);
        send_abc(1'b0, 1'b1, 1'b1);
        idle_bits(2);

        // 6: clean start, two frames, reset during DATA of the third
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        m_cnt = 0;
        m_sh = '0;
        idle_bits(2);
        send_abc(1'b1, 1'b1, 1'b1);
        send_abc(1'b1, 1'b1, 1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        rxd = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        rxd = 1'b1;
        #1;
        check_all_zero("midframe_reset");
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        m_cnt = 0;
        m_sh = '0;
        idle_bits(2);
        send_abc(1'b0, 1'b0, 1'b0);
        send_abc(1'b1, 1'b0, 1'b1);
        send_abc(1'b0, 1'b0, 1'b1);
        send_abc(1'b1, 1'b1, 1'b0);
        idle_bits(4);

        check("events_outstanding", 32'(ev_q.size()), 32'd0);
        check("words_outstanding", 32'(word_q.size()), 32'd0);
        check("final_word", 32'(word), 32'h6);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
